// File: rtl/acc_flit_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : acc_flit_arbiter_if
//  Purpose  : Bundle of the accelerator-side flit streams and the merged
//             NoC injection port seen by acc_flit_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface acc_flit_arbiter_if #(
  parameter int NUM_IN    = 2,
  parameter int FLIT_BITS = 32,
  parameter int SEL_BITS  = $clog2(NUM_IN)
);
  logic [NUM_IN*FLIT_BITS-1:0] in_data;
  logic [NUM_IN-1:0]           in_valid;
  logic [NUM_IN-1:0]           in_ready;
  logic [FLIT_BITS-1:0]        out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [SEL_BITS-1:0]         out_src;
  logic                        locked;

  // Arbiter side: consumes the streams, produces the merged port.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_src, locked
  );

  // Environment side: accelerators upstream plus the NoC downstream.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_src, locked
  );
endinterface
`default_nettype wire

// File: rtl/acc_flit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : acc_flit_arbiter
//  Purpose  : Round-robin merge of NUM_IN accelerator flit streams onto one
//             NoC injection port. A grant is held for a whole message, i.e.
//             until a flit with notFinalFlit=0 has been accepted.
//  Revision : 1.0 - initial release
// ============================================================================
module acc_flit_arbiter #(
  parameter int NUM_IN    = 2,
  parameter int SEL_BITS  = $clog2(NUM_IN),
  parameter int FLIT_BITS = 32,
  parameter int NF_BIT    = 0            // position of notFinalFlit in a flit
) (
  input  wire                  clk,
  input  wire                  rst_n,
  acc_flit_arbiter_if.slave    bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                r_state;
  logic                  r_full;
  logic [FLIT_BITS-1:0]  r_data;
  logic [SEL_BITS-1:0]   r_src;
  logic [SEL_BITS-1:0]   r_last;
  logic [SEL_BITS-1:0]   r_owner;

  logic                  w_space;
  logic                  w_hi_any;
  logic [SEL_BITS-1:0]   w_hi_sel;
  logic                  w_lo_any;
  logic [SEL_BITS-1:0]   w_lo_sel;
  logic [SEL_BITS-1:0]   w_sel;
  logic [SEL_BITS-1:0]   w_grant;
  logic [NUM_IN-1:0]     w_ready;
  logic                  w_push;
  logic [FLIT_BITS-1:0]  w_flit;

  // The output register can take a flit if empty or being drained this cycle.
  assign w_space = !r_full || bus.out_ready;

  // Rotating priority: lowest requester above lastGrant wins, else lowest overall.
  always_comb begin
    w_hi_any = 1'b0;
    w_hi_sel = '0;
    w_lo_any = 1'b0;
    w_lo_sel = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        if (i > int'(r_last)) begin
          w_hi_any = 1'b1;
          w_hi_sel = SEL_BITS'(i);
        end
        w_lo_any = 1'b1;
        w_lo_sel = SEL_BITS'(i);
      end
    end
    w_sel = w_hi_any ? w_hi_sel : w_lo_sel;
  end

  // Ready is one-hot on the winner; a locked owner keeps ready even when idle.
  always_comb begin
    w_grant = (r_state == ST_LOCKED) ? r_owner : w_sel;
    w_ready = '0;
    if (rst_n && w_space && ((r_state == ST_LOCKED) || w_lo_any)) begin
      w_ready = NUM_IN'(1) << w_grant;
    end
  end

  // Select the granted stream's flit for capture.
  always_comb begin
    w_flit = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (SEL_BITS'(i) == w_grant) begin
        w_flit = bus.in_data[i*FLIT_BITS +: FLIT_BITS];
      end
    end
  end

  assign w_push = |(bus.in_valid & w_ready);

  // Arbitration state and output buffer, updated on the falling edge.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_full  <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
      r_last  <= SEL_BITS'(NUM_IN - 1);
      r_owner <= '0;
    end else if (w_push) begin
      r_full <= 1'b1;
      r_data <= w_flit;
      r_src  <= w_grant;
      if (w_flit[NF_BIT]) begin
        r_state <= ST_LOCKED;
        r_owner <= w_grant;
      end else begin
        r_state <= ST_IDLE;
        r_last  <= w_grant;
      end
    end else if (bus.out_ready) begin
      r_full <= 1'b0;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_data  = r_data;
  assign bus.out_valid = r_full;
  assign bus.out_src   = r_src;
  assign bus.locked    = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_acc_flit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acc_flit_arbiter
//  Purpose  : Directed and randomized bench for acc_flit_arbiter with a
//             message-level reference model and per-source scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_acc_flit_arbiter;
  localparam int N  = 3;
  localparam int FB = 32;
  localparam int SB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  acc_flit_arbiter_if #(.NUM_IN(N), .FLIT_BITS(FB), .SEL_BITS(SB)) bus ();

  acc_flit_arbiter #(.NUM_IN(N), .SEL_BITS(SB), .FLIT_BITS(FB), .NF_BIT(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Upstream sources: message length, position in message, flit sequence.
  logic [N-1:0] s_valid;
  logic         out_ready_r;
  int           s_len [N];
  int           s_pos [N];
  int           s_seq [N];
  logic         s_idle[N];
  int           tx_msgs[N];
  int           rx_seq [N];
  int           rx_msgs[N];
  bit           rand_len;
  bit           rx_busy;
  int           rx_owner;

  // Reference model of the arbiter as seen from outside.
  bit              m_live;
  bit              m_full;
  bit              m_locked;
  int              m_src;
  int              m_owner;
  int              m_last;
  logic [FB-1:0]   m_data;

  logic [N-1:0]    last_ready;
  logic [FB-1:0]   held;
  int              n_pass;
  int              n_total;

  // Flit layout: [31:28] source, [27:12] sequence, [1] isIdleToken, [0] notFinalFlit.
  function automatic logic [FB-1:0] flit(int i);
    return {4'(i), 16'(s_seq[i]), 10'd0, s_idle[i], (s_pos[i] < s_len[i] - 1)};
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_full   = 1'b0;
    m_locked = 1'b0;
    m_src    = 0;
    m_owner  = 0;
    m_last   = N - 1;
    m_data   = '0;
  endtask

  // One clock: apply inputs at the rising edge, check, let the DUT act at the falling edge.
  task automatic cycle();
    logic [N-1:0]  er;
    logic [FB-1:0] f;
    bit            space;
    bit            push;
    int            g;
    for (int i = 0; i < N; i++) begin
      bus.in_valid[i]           = s_valid[i];
      bus.in_data[i*FB +: FB]   = flit(i);
    end
    bus.out_ready = out_ready_r;
    #1;
    er    = '0;
    g     = -1;
    f     = '0;
    space = !m_full || out_ready_r;
    if (rst_n && m_live && space) begin
      if (m_locked) begin
        g = m_owner;
      end else begin
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (m_last + k) % N;
          if (s_valid[idx]) begin
            g = idx;
            break;
          end
        end
      end
    end
    if (g >= 0) er[g] = 1'b1;
    last_ready = bus.in_ready;
    check("in_ready", 64'(bus.in_ready), 64'(er));
    if (m_live) begin
      check("out_valid", 64'(bus.out_valid), 64'(m_full));
      check("locked",    64'(bus.locked),    64'(m_locked));
      check("out_src",   64'(bus.out_src),   64'(m_src));
      check("out_data",  64'(bus.out_data),  64'(m_data));
    end
    push = (g >= 0) && s_valid[g];
    if (push) f = flit(g);
    if (rst_n && m_live && m_full && out_ready_r) begin
      check("rx_seq", 64'(bus.out_data[27:12]), 64'(16'(rx_seq[m_src])));
      if (rx_busy) check("no_interleave", 64'(bus.out_src), 64'(rx_owner));
      rx_seq[m_src]++;
      if (m_data[0]) begin
        rx_busy  = 1'b1;
        rx_owner = m_src;
      end else begin
        rx_busy  = 1'b0;
        rx_msgs[m_src]++;
      end
    end
    @(negedge clk);
    if (!rst_n) begin
      model_reset();
      m_live = 1'b1;
    end else if (push) begin
      m_full = 1'b1;
      m_data = f;
      m_src  = g;
      if (f[0]) begin
        m_locked = 1'b1;
        m_owner  = g;
      end else begin
        m_locked = 1'b0;
        m_last   = g;
      end
      s_seq[g]++;
      s_idle[g] = 1'($urandom_range(0, 1));
      s_pos[g]++;
      if (s_pos[g] == s_len[g]) begin
        s_pos[g] = 0;
        tx_msgs[g]++;
        s_len[g] = rand_len ? int'($urandom_range(1, 4)) : 1;
      end
    end else if (out_ready_r) begin
      m_full = 1'b0;
    end
    @(posedge clk);
  endtask

  initial begin
    bit done;
    n_pass = 0;
    n_total = 0;
    rand_len = 1'b0;
    rx_busy = 1'b0;
    rx_owner = 0;
    m_live = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) begin
      s_len[i] = 1; s_pos[i] = 0; s_seq[i] = 0; s_idle[i] = 1'b0;
      tx_msgs[i] = 0; rx_seq[i] = 0; rx_msgs[i] = 0;
    end
    s_valid = '0;
    out_ready_r = 1'b1;
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    @(posedge clk);

    // T1: reset held with all requesters active.
    rst_n = 1'b0;
    s_valid = '1;
    for (int c = 0; c < 4; c++) cycle();
    check("T1 out_valid", 64'(bus.out_valid), 64'(0));
    check("T1 locked",    64'(bus.locked),    64'(0));
    check("T1 out_src",   64'(bus.out_src),   64'(0));
    rst_n = 1'b1;

    // T2: fairness, single-flit messages from all three inputs.
    for (int c = 0; c < 6; c++) begin
      s_valid = '1;
      cycle();
      check("T2 order", 64'(bus.out_src), 64'(c % 3));
      check("T2 valid", 64'(bus.out_valid), 64'(1));
    end
    s_valid = '0;
    cycle();

    // T3: three-flit message from input 0 holds off input 1.
    s_len[0] = 3;
    s_len[1] = 1;
    for (int c = 0; c < 4; c++) begin
      s_valid = 3'b011;
      cycle();
      check("T3 src",    64'(bus.out_src), 64'((c < 3) ? 0 : 1));
      check("T3 locked", 64'(bus.locked),  64'((c < 2) ? 1 : 0));
    end
    s_valid = '0;
    cycle();

    // T4: owner pauses mid-message; input 1 must stay blocked.
    s_len[0] = 3;
    s_valid = 3'b011;
    cycle();
    check("T4 first", 64'(bus.out_src), 64'(0));
    for (int c = 0; c < 4; c++) begin
      s_valid = 3'b010;
      cycle();
      check("T4 blocked", 64'(last_ready[1]), 64'(0));
    end
    for (int c = 0; c < 3; c++) begin
      s_valid = 3'b011;
      cycle();
      check("T4 src", 64'(bus.out_src), 64'((c < 2) ? 0 : 1));
    end
    s_valid = '0;
    cycle();

    // T5: downstream stalls with the buffer full, then releases.
    s_valid = '1;
    out_ready_r = 1'b0;
    cycle();
    held = bus.out_data;
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("T5 stable", 64'(bus.out_data), 64'(held));
      check("T5 ready",  64'(last_ready),   64'(0));
    end
    out_ready_r = 1'b1;
    for (int c = 0; c < 6; c++) cycle();
    s_valid = '0;
    cycle();

    // T6: random traffic with 1-4 flit messages.
    rand_len = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) s_valid[i] = ($urandom_range(0, 3) != 0);
      out_ready_r = ($urandom_range(0, 2) != 0);
      cycle();
    end

    // Let any open message finish, then drain the buffer.
    done = 1'b0;
    out_ready_r = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      for (int i = 0; i < N; i++) s_valid[i] = (s_pos[i] != 0);
      cycle();
      done = !m_full && (s_pos[0] == 0) && (s_pos[1] == 0) && (s_pos[2] == 0);
    end
    check("drain_done", 64'(done), 64'(1));
    for (int i = 0; i < N; i++) begin
      check("msgs_delivered", 64'(rx_msgs[i]), 64'(tx_msgs[i]));
      check("msgs_nonzero",   64'(tx_msgs[i] > 10), 64'(1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
